// File: rtl/turn_game_pkg.sv
// Shared types and constants for the turn-order game controller.
package turn_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam logic [2:0] MV_FWD1 = 3'b100;
  localparam logic [2:0] MV_FWD2 = 3'b101;
  localparam logic [2:0] MV_BCK1 = 3'b010;
  localparam logic [2:0] MV_BCK2 = 3'b001;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_INVALID = 2'b01;
  localparam logic [1:0] CAUSE_WRONG   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       fwd;
    logic [1:0] mag;
  } move_t;

  // Decode a 3-bit move code into direction and step size.
  function automatic move_t decode_move(input logic [2:0] code);
    move_t m;
    m = '0;
    case (code)
      MV_FWD1: m = '{valid: 1'b1, fwd: 1'b1, mag: 2'd1};
      MV_FWD2: m = '{valid: 1'b1, fwd: 1'b1, mag: 2'd2};
      MV_BCK1: m = '{valid: 1'b1, fwd: 1'b0, mag: 2'd1};
      MV_BCK2: m = '{valid: 1'b1, fwd: 1'b0, mag: 2'd2};
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/press_edge_detect.sv
// Rising-edge detector for the per-player buttons; history resets to all ones
// so a button already held at reset never produces an event.
module press_edge_detect #(
  parameter int N = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_press,
  output logic [N-1:0] o_event
);

  logic [N-1:0] r_prev;

  // Press history, updated every cycle regardless of game state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= '1;
    else       r_prev <= i_press;
  end

  assign o_event = i_press & ~r_prev;

endmodule

// File: rtl/turn_game_ctrl.sv
// Turn-order game core: tracks the current player, applies move steps
// modulo N_PLAYERS and declares a loser on invalid/out-of-turn/timeout.
module turn_game_ctrl
  import turn_game_pkg::*;
#(
  parameter int N_PLAYERS      = 6,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8,
  localparam int PW            = $clog2(N_PLAYERS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PW-1:0]          first_player,
  input  logic [N_PLAYERS-1:0]   press,
  input  logic [3*N_PLAYERS-1:0] move,
  output logic [PW-1:0]          turn,
  output logic                   game_over,
  output logic [PW-1:0]          loser,
  output logic [1:0]             loss_cause,
  output logic [CNT_W-1:0]       move_count,
  output logic [1:0]             state_out
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PW:0]   N_EXT   = (PW + 1)'(N_PLAYERS);

  state_t               r_state, w_state_nxt;
  logic [PW-1:0]        r_turn, w_turn_nxt;
  logic [PW-1:0]        r_loser, w_loser_nxt;
  logic [1:0]           r_cause, w_cause_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic [TW-1:0]        r_tmo, w_tmo_nxt;
  logic [N_PLAYERS-1:0] w_event;

  logic [PW-1:0] w_offender;
  logic          w_cur_evt;
  logic [2:0]    w_cur_code;
  move_t         w_mv;
  logic [PW:0]   w_idx, w_sum, w_mag;
  logic [PW-1:0] w_next_turn, w_first;

  press_edge_detect #(.N(N_PLAYERS)) u_edge (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_press (press),
    .o_event (w_event)
  );

  // Decode events: lowest out-of-turn offender, current player's event and code, next turn.
  always_comb begin
    w_offender = '0;
    w_cur_evt  = 1'b0;
    w_cur_code = '0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (r_turn == PW'(i + 1)) begin
        w_cur_evt  = w_event[i];
        w_cur_code = move[3*i +: 3];
      end else if (w_event[i] && (w_offender == '0)) begin
        w_offender = PW'(i + 1);
      end
    end
    w_mv  = decode_move(w_cur_code);
    w_mag = (PW + 1)'(w_mv.mag);
    w_idx = {1'b0, r_turn} - 1'b1;
    // Wrap by a single compare-and-correct; the step never exceeds 2 < N.
    if (w_mv.fwd) begin
      w_sum = w_idx + w_mag;
      if (w_sum >= N_EXT) w_sum = w_sum - N_EXT;
    end else if (w_idx >= w_mag) begin
      w_sum = w_idx - w_mag;
    end else begin
      w_sum = w_idx + N_EXT - w_mag;
    end
    w_next_turn = PW'(w_sum + 1'b1);
    w_first = ((first_player == '0) || (first_player > PW'(N_PLAYERS))) ? PW'(1) : first_player;
  end

  // Next-state and datapath update with start taking priority over everything.
  always_comb begin
    w_state_nxt = r_state;
    w_turn_nxt  = r_turn;
    w_loser_nxt = r_loser;
    w_cause_nxt = r_cause;
    w_count_nxt = r_count;
    w_tmo_nxt   = r_tmo;
    if (start) begin
      w_state_nxt = ST_PLAY;
      w_turn_nxt  = w_first;
      w_loser_nxt = '0;
      w_cause_nxt = CAUSE_NONE;
      w_count_nxt = '0;
      w_tmo_nxt   = '0;
    end else if (r_state == ST_PLAY) begin
      if (w_offender != '0) begin
        w_state_nxt = ST_OVER;
        w_loser_nxt = w_offender;
        w_cause_nxt = CAUSE_WRONG;
        w_turn_nxt  = '0;
      end else if (w_cur_evt && !w_mv.valid) begin
        w_state_nxt = ST_OVER;
        w_loser_nxt = r_turn;
        w_cause_nxt = CAUSE_INVALID;
        w_turn_nxt  = '0;
      end else if (w_cur_evt) begin
        w_turn_nxt = w_next_turn;
        if (r_count != '1) w_count_nxt = r_count + 1'b1;
        w_tmo_nxt = '0;
      end else if ((TIMEOUT_CYCLES != 0) && (r_tmo == TO_LAST)) begin
        w_state_nxt = ST_OVER;
        w_loser_nxt = r_turn;
        w_cause_nxt = CAUSE_TIMEOUT;
        w_turn_nxt  = '0;
      end else if (TIMEOUT_CYCLES != 0) begin
        w_tmo_nxt = r_tmo + 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_turn  <= '0;
      r_loser <= '0;
      r_cause <= CAUSE_NONE;
      r_count <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_turn  <= w_turn_nxt;
      r_loser <= w_loser_nxt;
      r_cause <= w_cause_nxt;
      r_count <= w_count_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign turn       = r_turn;
  assign game_over  = (r_state == ST_OVER);
  assign loser      = r_loser;
  assign loss_cause = r_cause;
  assign move_count = r_count;
  assign state_out  = r_state;

endmodule

// File: tb/tb_turn_game_ctrl.sv
// Randomized and directed bench for turn_game_ctrl with a game-level reference model.
module tb_turn_game_ctrl;

  localparam int N  = 6;
  localparam int TO = 10;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [PW-1:0]   first_player = '0;
  logic [N-1:0]    press = '0;
  logic [3*N-1:0]  move = '0;
  logic [PW-1:0]   turn;
  logic            game_over;
  logic [PW-1:0]   loser;
  logic [1:0]      loss_cause;
  logic [7:0]      move_count;
  logic [1:0]      state_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: game state as plain integers.
  int m_state;   // 0 idle, 1 play, 2 over
  int m_turn, m_loser, m_cause, m_count, m_idle;
  logic [N-1:0] m_prev;

  turn_game_ctrl #(.N_PLAYERS(N), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .first_player (first_player),
    .press        (press),
    .move         (move),
    .turn         (turn),
    .game_over    (game_over),
    .loser        (loser),
    .loss_cause   (loss_cause),
    .move_count   (move_count),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_turn = 0; m_loser = 0; m_cause = 0; m_count = 0; m_idle = 0;
    m_prev = '1;
  endtask

  task automatic model_over(input int who, input int cause);
    m_state = 2; m_loser = who; m_cause = cause; m_turn = 0;
  endtask

  task automatic model_edge(input logic st, input int fp, input logic [N-1:0] pr, input logic [3*N-1:0] mv);
    logic [N-1:0] ev;
    logic [2:0]   code;
    int off, stp;
    ev = pr & ~m_prev;
    m_prev = pr;
    if (st) begin
      m_state = 1;
      m_turn  = (fp < 1 || fp > N) ? 1 : fp;
      m_count = 0; m_loser = 0; m_cause = 0; m_idle = 0;
    end else if (m_state == 1) begin
      off = 0;
      for (int p = 1; p <= N; p++)
        if (ev[p-1] && p != m_turn && off == 0) off = p;
      if (off != 0) begin
        model_over(off, 2);
      end else if (ev[m_turn-1]) begin
        code = mv[3*(m_turn-1) +: 3];
        case (code)
          3'b100:  stp = 1;
          3'b101:  stp = 2;
          3'b010:  stp = -1;
          3'b001:  stp = -2;
          default: stp = 0;
        endcase
        if (stp == 0) model_over(m_turn, 1);
        else begin
          m_turn  = ((m_turn - 1 + stp + N) % N) + 1;
          m_count = (m_count == 255) ? 255 : m_count + 1;
          m_idle  = 0;
        end
      end else if (m_idle == TO - 1) begin
        model_over(m_turn, 3);
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".turn"},  32'(turn),       32'(m_turn));
    chk({tag, ".state"}, 32'(state_out),  32'(m_state));
    chk({tag, ".over"},  32'(game_over),  32'(m_state == 2));
    chk({tag, ".loser"}, 32'(loser),      32'(m_loser));
    chk({tag, ".cause"}, 32'(loss_cause), 32'(m_cause));
    chk({tag, ".count"}, 32'(move_count), 32'(m_count));
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 ns later.
  task automatic step(input string tag, input logic st, input int fp, input logic [N-1:0] pr, input logic [3*N-1:0] mv);
    @(negedge clk);
    start = st; first_player = PW'(fp); press = pr; move = mv;
    @(posedge clk);
    model_edge(st, fp, pr, mv);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [3*N-1:0] mv_at(input int p, input logic [2:0] code);
    logic [3*N-1:0] v;
    v = '0;
    v[3*(p-1) +: 3] = code;
    return v;
  endfunction

  function automatic logic [N-1:0] btn(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p-1] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [N-1:0]   pr;
    logic [3*N-1:0] mv;
    int r, fp;

    model_reset();
    do_reset("reset");
    chk("reset_turn", 32'(turn), 0);

    // 1: basic advance
    step("t1_start", 1'b1, 1, '0, '0);
    step("t1_move", 1'b0, 0, btn(1), mv_at(1, 3'b100));
    chk("t1_turn2", 32'(turn), 2);
    chk("t1_cnt1", 32'(move_count), 1);

    // 2: backward and wrap
    step("t2_start", 1'b1, 1, '0, '0);
    step("t2_m2", 1'b0, 0, btn(1), mv_at(1, 3'b001));
    chk("t2_turn5", 32'(turn), 5);
    step("t2_rel", 1'b0, 0, '0, '0);
    step("t2_p2", 1'b0, 0, btn(5), mv_at(5, 3'b101));
    chk("t2_turn1", 32'(turn), 1);

    // 3: simultaneous presses, out-of-turn wins
    step("t3_start", 1'b1, 3, '0, '0);
    step("t3_dual", 1'b0, 0, btn(2) | btn(3), mv_at(3, 3'b100) | mv_at(2, 3'b100));
    chk("t3_loser", 32'(loser), 2);
    chk("t3_cause", 32'(loss_cause), 2);
    chk("t3_cnt", 32'(move_count), 0);

    // 4: invalid code, then frozen outputs
    step("t4_start", 1'b1, 4, '0, '0);
    step("t4_bad", 1'b0, 0, btn(4), mv_at(4, 3'b111));
    chk("t4_loser", 32'(loser), 4);
    chk("t4_cause", 32'(loss_cause), 1);
    step("t4_rel", 1'b0, 0, '0, '0);
    step("t4_more", 1'b0, 0, btn(1) | btn(4), mv_at(4, 3'b100));
    chk("t4_hold", 32'(loser), 4);

    // 5a: timeout after 10 idle cycles
    step("t5_start", 1'b1, 1, '0, '0);
    step("t5_move", 1'b0, 0, btn(1), mv_at(1, 3'b100));
    for (int i = 0; i < TO - 1; i++) step("t5_idle", 1'b0, 0, '0, '0);
    chk("t5_still_play", 32'(state_out), 1);
    step("t5_expire", 1'b0, 0, '0, '0);
    chk("t5_cause", 32'(loss_cause), 3);
    chk("t5_loser", 32'(loser), 2);

    // 5b: press on the last cycle is accepted
    step("t5b_start", 1'b1, 1, '0, '0);
    step("t5b_move", 1'b0, 0, btn(1), mv_at(1, 3'b100));
    for (int i = 0; i < TO - 1; i++) step("t5b_idle", 1'b0, 0, '0, '0);
    step("t5b_last", 1'b0, 0, btn(2), mv_at(2, 3'b100));
    chk("t5b_turn3", 32'(turn), 3);
    chk("t5b_play", 32'(state_out), 1);

    // 6: held button through reset/start, out-of-range first player, async reset
    @(negedge clk); press = btn(1);
    do_reset("t6_rst");
    step("t6_start", 1'b1, 7, btn(1), mv_at(1, 3'b100));
    chk("t6_turn1", 32'(turn), 1);
    step("t6_held", 1'b0, 0, btn(1), mv_at(1, 3'b100));
    chk("t6_noevt", 32'(move_count), 0);
    step("t6_rel", 1'b0, 0, '0, '0);
    step("t6_mv", 1'b0, 0, btn(1), mv_at(1, 3'b100));
    do_reset("t6_mid");
    chk("t6_mid_turn", 32'(turn), 0);
    chk("t6_mid_state", 32'(state_out), 0);
    chk("t6_mid_cnt", 32'(move_count), 0);

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      r  = $urandom_range(0, 99);
      fp = $urandom_range(0, 7);
      mv = '0;
      for (int p = 1; p <= N; p++) begin
        case ($urandom_range(0, 5))
          0: mv[3*(p-1) +: 3] = 3'b100;
          1: mv[3*(p-1) +: 3] = 3'b101;
          2: mv[3*(p-1) +: 3] = 3'b010;
          3: mv[3*(p-1) +: 3] = 3'b001;
          default: mv[3*(p-1) +: 3] = 3'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) < 45) pr = '0;
      else if ($urandom_range(0, 99) < 85) pr = (m_turn >= 1 && m_turn <= N) ? btn(m_turn) : btn($urandom_range(1, N));
      else pr = N'($urandom);
      if (r < 2) do_reset("rnd_rst");
      else step("rnd", (r < 8), fp, pr, mv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
